lsu_dmem_master: RTL

- Load/store initiator on the core side of the data memory interface.
- Takes one RV32 load/store request at a time from the execute stage and converts it into word-aligned memory transactions.
- Stores: builds byte enables and replicated lane data.
- Loads: extracts and sign/zero-extends the addressed byte or half.
- Drives the request end of the data memory port; the memory is the responder.

---
 rtl/lsu_dmem_master.sv | 125 ++++++++++++
 1 files changed

// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: RV32 load/store initiator driving a word-aligned data memory port
module lsu_dmem_master #(
  parameter int TIMEOUT    = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [2:0]            i_req_funct3,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [31:0]           i_req_wdata,
  output logic                  o_resp_valid,
  output logic [31:0]           o_resp_rdata,
  output logic [1:0]            o_resp_err,
  output logic                  o_mem_req,
  input  logic                  i_mem_gnt,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [3:0]            o_mem_be,
  output logic [31:0]           o_mem_wdata,
  input  logic                  i_mem_rvalid,
  input  logic [31:0]           i_mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, RESP} state_t;
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [1:0]  w_off;
  logic        w_illegal;
  logic        w_misaligned;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_ext;
  always_comb begin
    w_off        = i_req_addr[1:0];
    w_illegal    = i_req_we ? (i_req_funct3[2] || i_req_funct3[1:0] == 2'b11)
                            : (i_req_funct3[1:0] == 2'b11 || i_req_funct3 == 3'b110);
    w_misaligned = (i_req_funct3[1:0] == 2'b01 && w_off[0]) ||
                   (i_req_funct3[1:0] == 2'b10 && w_off != 2'b00);
    w_be         = !i_req_we                   ? 4'b1111 :
                   i_req_funct3[1:0] == 2'b00 ? 4'b0001 << w_off :
                   i_req_funct3[1:0] == 2'b01 ? 4'b0011 << w_off : 4'b1111;
    w_wdata      = !i_req_we                   ? 32'h0 :
                   i_req_funct3[1:0] == 2'b00 ? {4{i_req_wdata[7:0]}} :
                   i_req_funct3[1:0] == 2'b01 ? {2{i_req_wdata[15:0]}} : i_req_wdata;
    w_shifted    = i_mem_rdata >> {r_off, 3'b000};
    w_ext        = r_funct3 == 3'b000 ? {{24{w_shifted[7]}}, w_shifted[7:0]} :
                   r_funct3 == 3'b001 ? {{16{w_shifted[15]}}, w_shifted[15:0]} :
                   r_funct3 == 3'b100 ? {24'h0, w_shifted[7:0]} :
                   r_funct3 == 3'b101 ? {16'h0, w_shifted[15:0]} : w_shifted;
    w_timeout    = r_cnt == 8'(TIMEOUT - 1);
  end
  // Every response path loads resp_rdata/resp_err together so they hold until the next RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_funct3     <= '0;
      r_off        <= '0;
      o_req_ready  <= 1'b1;
      o_resp_valid <= 1'b0;
      o_resp_rdata <= '0;
      o_resp_err   <= '0;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_be     <= '0;
      o_mem_wdata  <= '0;
    end else begin
      o_resp_valid <= 1'b0;
      case (r_state)
        IDLE: if (i_req_valid) begin
          r_funct3    <= i_req_funct3;
          r_off       <= w_off;
          o_req_ready <= 1'b0;
          if (w_illegal || w_misaligned) begin
            r_state      <= RESP;
            o_resp_valid <= 1'b1;
            o_resp_rdata <= '0;
            o_resp_err   <= w_illegal ? 2'b10 : 2'b01;
          end else begin
            r_state     <= ISSUE;
            r_cnt       <= '0;
            o_mem_req   <= 1'b1;
            o_mem_we    <= i_req_we;
            o_mem_addr  <= {i_req_addr[ADDR_WIDTH-1:2], 2'b00};
            o_mem_be    <= w_be;
            o_mem_wdata <= w_wdata;
          end
        end
        ISSUE: if (i_mem_gnt) begin
          o_mem_req <= 1'b0;
          r_cnt     <= '0;
          if (o_mem_we) begin
            r_state      <= RESP;
            o_resp_valid <= 1'b1;
            o_resp_rdata <= '0;
            o_resp_err   <= 2'b00;
          end else r_state <= WAIT_R;
        end else if (w_timeout) begin
          o_mem_req    <= 1'b0;
          r_state      <= RESP;
          o_resp_valid <= 1'b1;
          o_resp_rdata <= '0;
          o_resp_err   <= 2'b11;
        end else r_cnt <= r_cnt + 8'd1;
        WAIT_R: if (i_mem_rvalid || w_timeout) begin
          r_state      <= RESP;
          o_resp_valid <= 1'b1;
          o_resp_rdata <= i_mem_rvalid ? w_ext : 32'h0;
          o_resp_err   <= i_mem_rvalid ? 2'b00 : 2'b11;
        end else r_cnt <= r_cnt + 8'd1;
        default: begin
          r_state     <= IDLE;
          o_req_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
